// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state type, LCD command constants and helpers
//
// Contents:
//   lcd_state_t      bus-engine state (PWR, IDLE, SETUP, EN, HOLD, WAIT)
//   LCD_* constants  init command bytes and DDRAM line base addresses
//   init_cmd()       init command byte by sequence index
//   needs_long_wait() true for clear/return-home commands (rs=0, data[7:2]==0)
//   max2()           constant helper used to size the shared down-counter
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_IDLE,
        ST_SETUP,
        ST_EN,
        ST_HOLD,
        ST_WAIT
    } lcd_state_t;

    // HD44780-style init commands: 8-bit bus / 2 lines / 5x10 font,
    // display on with cursor off, increment without shift, clear.
    localparam logic [7:0] LCD_FUNC_SET = 8'h3C;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_HOME     = 8'h02;

    // Set-DDRAM-address commands for the start of each display line.
    localparam logic [7:0] LCD_LINE0_ADDR = 8'h80;
    localparam logic [7:0] LCD_LINE1_ADDR = 8'hC0;

    localparam int LCD_INIT_LEN = 4;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return LCD_FUNC_SET;
            3'd1:    return LCD_DISP_ON;
            3'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) are the only commands with
    // the slow execution time; every other command and all data writes are fast.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_xfer_timer.sv
// rtl/lcd_xfer_timer.sv - power-up wait plus SETUP/EN/HOLD/WAIT transfer engine
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           begin a transfer (only honoured in IDLE)
//   rs, data        register select and byte latched on start
//   long_wait       use CLR_WAIT instead of CMD_WAIT after this transfer
//   idle            engine is in IDLE and can accept start this cycle
//   done            last WAIT cycle; the engine enters IDLE on this edge
//   busy            registered, high while the engine is not in IDLE
//   lcd_e           LCD enable strobe
//   lcd_rs, lcd_data LCD bus, held between transfers
//
// All timed states share one down-counter sized for the largest parameter.
// Each state loads (length-1) on entry and leaves when the counter hits zero,
// so a state lasts exactly its parameter in cycles.
module lcd_xfer_timer
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT  = 7000,
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 5,
    parameter int HOLD_CYC  = 2,
    parameter int CMD_WAIT  = 40,
    parameter int CLR_WAIT  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       idle,
    output logic       done,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int MAX_CYC = max2(max2(max2(PWR_WAIT, SETUP_CYC), max2(E_CYC, HOLD_CYC)),
                                  max2(CMD_WAIT, CLR_WAIT));
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWR_LOAD   = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] E_LOAD     = CW'(E_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LOAD   = CW'(CLR_WAIT - 1);

    lcd_state_t    state;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          wait_long;

    assign cnt_zero = (cnt == '0);
    assign idle     = (state == ST_IDLE);
    assign done     = (state == ST_WAIT) && cnt_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_PWR;
            cnt       <= PWR_LOAD;
            wait_long <= 1'b0;
            busy      <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            case (state)
                ST_PWR: begin
                    busy <= 1'b1;
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SETUP;
                        cnt       <= SETUP_LOAD;
                        busy      <= 1'b1;
                        lcd_rs    <= rs;
                        lcd_data  <= data;
                        wait_long <= long_wait;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        state <= ST_EN;
                        cnt   <= E_LOAD;
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_EN: begin
                    if (cnt_zero) begin
                        state <= ST_HOLD;
                        cnt   <= HOLD_LOAD;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state <= ST_WAIT;
                        cnt   <= wait_long ? CLR_LOAD : CMD_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    lcd_e <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// rtl/lcd_bus_scheduler.sv - shares the character-LCD write bus between two requesters
//
// Runs the LCD power-up init sequence after reset, then grants write
// transfers to req0/req1 with a req/ack handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   req0, rs0, data0      requester 0: request, register select, byte
//   ack0                  one-cycle pulse when request 0 is latched
//   req1, rs1, data1      requester 1: same rules
//   ack1                  one-cycle pulse when request 1 is latched
//   ready                 init sequence complete; stays high until reset
//   busy                  transfer engine not idle
//   lcd_e, lcd_rs, lcd_rw, lcd_data   LCD pins (lcd_rw tied low)
//
// Build option LCD_FIXED_PRIO_EN: when defined, req0 always beats req1 and
// the round-robin pointer is removed; when undefined, ties alternate.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT  = 7000,
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 5,
    parameter int HOLD_CYC  = 2,
    parameter int CMD_WAIT  = 40,
    parameter int CLR_WAIT  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       ready,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam logic [2:0] INIT_LAST = 3'(LCD_INIT_LEN);

    logic       idle;
    logic       done;
    logic       start;
    logic       start_rs;
    logic [7:0] start_data;
    logic       start_long;
    logic       init_go;
    logic       grant_any;
    logic       grant1;
    logic [2:0] init_idx;   // number of init commands already issued

`ifndef LCD_FIXED_PRIO_EN
    logic       rr_last;    // 1 when port 1 had the most recent grant
`endif

    always_comb begin
        init_go   = idle && !ready && (init_idx < INIT_LAST);
        grant_any = idle && ready && (req0 || req1);
`ifdef LCD_FIXED_PRIO_EN
        grant1    = !req0;
`else
        grant1    = req1 && (!req0 || !rr_last);
`endif
        start      = init_go || grant_any;
        start_rs   = 1'b0;
        start_data = init_cmd(init_idx);
        if (!init_go) begin
            start_rs   = grant1 ? rs1   : rs0;
            start_data = grant1 ? data1 : data0;
        end
        start_long = needs_long_wait(start_rs, start_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            ready    <= 1'b0;
            init_idx <= 3'd0;
`ifndef LCD_FIXED_PRIO_EN
            rr_last  <= 1'b1;
`endif
        end else begin
            ack0 <= grant_any && !grant1;
            ack1 <= grant_any && grant1;
            if (init_go) begin
                init_idx <= init_idx + 3'd1;
            end
            // ready rises on the same edge the final init WAIT returns to IDLE.
            if (done && !ready && (init_idx == INIT_LAST)) begin
                ready <= 1'b1;
            end
`ifndef LCD_FIXED_PRIO_EN
            if (grant_any) begin
                rr_last <= grant1;
            end
`endif
        end
    end

    lcd_xfer_timer #(
        .PWR_WAIT (PWR_WAIT),
        .SETUP_CYC(SETUP_CYC),
        .E_CYC    (E_CYC),
        .HOLD_CYC (HOLD_CYC),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rs       (start_rs),
        .data     (start_data),
        .long_wait(start_long),
        .idle     (idle),
        .done     (done),
        .busy     (busy),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb/tb_lcd_bus_scheduler.sv - randomized scoreboard bench for lcd_bus_scheduler
module tb_lcd_bus_scheduler;

    localparam int P_PWR   = 50;
    localparam int P_SETUP = 2;
    localparam int P_E     = 3;
    localparam int P_HOLD  = 2;
    localparam int P_CMD   = 6;
    localparam int P_CLR   = 15;
    localparam logic [7:0] INIT_SEQ [4] = '{8'h3C, 8'h0C, 8'h06, 8'h01};

    logic       clk;
    logic       rst;
    logic [1:0] req_v;
    logic [1:0] rs_v;
    logic [7:0] data_v [2];
    logic       ack0, ack1, ready, busy, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_bus_scheduler #(
        .PWR_WAIT(P_PWR), .SETUP_CYC(P_SETUP), .E_CYC(P_E),
        .HOLD_CYC(P_HOLD), .CMD_WAIT(P_CMD), .CLR_WAIT(P_CLR)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req_v[0]), .rs0(rs_v[0]), .data0(data_v[0]), .ack0(ack0),
        .req1(req_v[1]), .rs1(rs_v[1]), .data1(data_v[1]), .ack1(ack1),
        .ready(ready), .busy(busy),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int port; int cyc; } ack_t;
    typedef struct { logic rs; logic [7:0] data; int rise; } xfer_t;
    ack_t  aq[$];
    xfer_t xq[$];
    int    cyc;
    int    next_acc;
    int    ready_edge;
    int    last_port;

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        if (!rs && d < 8'd4) return P_CLR;
        return P_CMD;
    endfunction

    // Cycle budget of one transfer counted from its accept edge to the next
    // possible accept edge.
    function automatic int xfer_len(input logic rs, input logic [7:0] d);
        return P_SETUP + P_E + P_HOLD + wait_of(rs, d) + 1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            int a;
            xfer_t x;
            cyc = 0;
            last_port = 1;
            aq.delete();
            xq.delete();
            a = P_PWR + 1;
            for (int k = 0; k < 4; k++) begin
                x.rs = 1'b0;
                x.data = INIT_SEQ[k];
                x.rise = a + P_SETUP;
                xq.push_back(x);
                a = a + xfer_len(1'b0, INIT_SEQ[k]);
            end
            ready_edge = a - 1;
            next_acc = a;
        end else begin
            cyc++;
            if (cyc >= next_acc && (req_v[0] || req_v[1])) begin
                int p;
                ack_t ak;
                xfer_t x;
`ifdef LCD_FIXED_PRIO_EN
                p = req_v[0] ? 0 : 1;
`else
                if (req_v[0] && req_v[1]) p = (last_port == 0) ? 1 : 0;
                else p = req_v[0] ? 0 : 1;
`endif
                last_port = p;
                ak.port = p;
                ak.cyc = cyc;
                aq.push_back(ak);
                x.rs = rs_v[p];
                x.data = data_v[p];
                x.rise = cyc + P_SETUP;
                xq.push_back(x);
                next_acc = cyc + xfer_len(rs_v[p], data_v[p]);
            end
        end
    end

    // ---------------- monitor ----------------
    logic       prev_e = 1'b0;
    int         rise_cyc = 0;
    logic       hold_rs = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            prev_e = 1'b0;
        end else begin
            logic e0, e1;
            xfer_t x;
            e0 = (aq.size() > 0) && (aq[0].cyc == cyc) && (aq[0].port == 0);
            e1 = (aq.size() > 0) && (aq[0].cyc == cyc) && (aq[0].port == 1);
            chk("ack0", ack0, e0);
            chk("ack1", ack1, e1);
            if (aq.size() > 0 && aq[0].cyc <= cyc) void'(aq.pop_front());
            chk("ready", ready, (cyc >= ready_edge));
            if (lcd_e && !prev_e) begin
                if (xq.size() == 0) begin
                    chk("lcd_e_unexpected_rise", 1, 0);
                end else begin
                    x = xq.pop_front();
                    chk("rise_cycle", cyc, x.rise);
                    chk("lcd_rs", lcd_rs, x.rs);
                    chk("lcd_data", lcd_data, x.data);
                end
                chk("lcd_rw", lcd_rw, 0);
                chk("busy_in_xfer", busy, 1);
                rise_cyc = cyc;
                hold_rs = lcd_rs;
                hold_data = lcd_data;
            end else if (!lcd_e && prev_e) begin
                chk("e_width", cyc - rise_cyc, P_E);
            end else if (lcd_e) begin
                chk("bus_stable", {hold_rs, hold_data} == {lcd_rs, lcd_data}, 1);
            end
            if (xq.size() > 0 && xq[0].rise < cyc) begin
                chk("lcd_e_missing", 0, 1);
                void'(xq.pop_front());
            end
            prev_e = lcd_e;
        end
    end

    // ---------------- requester agents ----------------
    // mode 0: idle, 1: hold a fixed request, 2: random requests with random drops
    int         mode [2];
    logic       fix_rs [2];
    logic [7:0] fix_data [2];

    initial begin
        req_v = 2'b00;
        rs_v = 2'b00;
        data_v[0] = 8'h00;
        data_v[1] = 8'h00;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                logic ak;
                ak = (p == 0) ? ack0 : ack1;
                case (mode[p])
                    1: begin
                        req_v[p] = 1'b1;
                        rs_v[p] = fix_rs[p];
                        data_v[p] = fix_data[p];
                    end
                    2: begin
                        if (req_v[p]) begin
                            if (ak || $urandom_range(0, 63) == 0) req_v[p] = 1'b0;
                        end else if ($urandom_range(0, 3) == 0) begin
                            req_v[p] = 1'b1;
                            rs_v[p] = 1'($urandom_range(0, 1));
                            if ($urandom_range(0, 3) == 0) data_v[p] = 8'($urandom_range(0, 3));
                            else data_v[p] = 8'($urandom_range(0, 255));
                        end
                    end
                    default: req_v[p] = 1'b0;
                endcase
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_lcd_e"}, lcd_e, 0);
        chk({tag, "_lcd_rs"}, lcd_rs, 0);
        chk({tag, "_lcd_rw"}, lcd_rw, 0);
        chk({tag, "_lcd_data"}, lcd_data, 0);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        mode[0] = 1; fix_rs[0] = 1'b1; fix_data[0] = 8'h48;
        mode[1] = 0; fix_rs[1] = 1'b1; fix_data[1] = 8'h42;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        #2 rst = 1'b1;

        // request held from before reset release: served on the first ready IDLE
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (ack0) seen = 1;
        end
        chk("first_ack0_seen", seen, 1);
        mode[0] = 0;

        // both held: alternate (round-robin) or port 0 only (fixed priority)
        fix_data[0] = 8'h41; fix_rs[0] = 1'b1;
        fix_data[1] = 8'h42; fix_rs[1] = 1'b1;
        mode[0] = 1; mode[1] = 1;
        repeat (150) @(negedge clk);

        // port 0 drops; port 1 issues clear then a line address
        mode[0] = 0;
        fix_rs[1] = 1'b0; fix_data[1] = 8'h01;
        repeat (60) @(negedge clk);
        fix_data[1] = 8'h80;
        repeat (60) @(negedge clk);

        // randomized traffic
        mode[0] = 2; mode[1] = 2;
        repeat (3000) @(negedge clk);

        // reset while lcd_e is high
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (lcd_e) seen = 1;
        end
        chk("lcd_e_high_before_reset", seen, 1);
        #1 rst = 1'b0;
        #1 check_all_zero("midreset");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (800) @(negedge clk);

        // drain
        mode[0] = 0; mode[1] = 0;
        for (int i = 0; i < 400 && (xq.size() != 0 || aq.size() != 0); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("xfer_queue_drained", xq.size(), 0);
        chk("ack_queue_drained", aq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_bus_scheduler.md
Name: lcd_bus_scheduler

Overview:
Owns the character-LCD bus (lcd_e/lcd_rs/lcd_rw/lcd_data) and shares it between two requesters through a req/ack handshake.
After reset it runs the LCD power-up init sequence itself, then grants write transfers round-robin.
Every transfer gets correct setup, enable-pulse, hold and post-command wait timing.
Sits between display-content logic (score and message writers) and the LCD pins, replacing free-running per-design LCD state machines.

Parameters:
PWR_WAIT, 7000, clk cycles idle after reset before the first init command
SETUP_CYC, 2, cycles lcd_rs/lcd_data are stable before lcd_e rises (>=1)
E_CYC, 5, cycles lcd_e is high (>=1)
HOLD_CYC, 2, cycles lcd_rs/lcd_data are held after lcd_e falls (>=1)
CMD_WAIT, 40, post-transfer wait for ordinary commands and data (>=1)
CLR_WAIT, 200, post-transfer wait for clear/home commands (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req0  in  1  requester 0 transfer request; held with rs0/data0 stable until ack0
rs0  in  1  requester 0 register select (0 = command, 1 = data)
data0  in  8  requester 0 byte
ack0  out  1  one-cycle pulse; request 0 accepted and latched
req1  in  1  requester 1 request, same rules
rs1  in  1  requester 1 register select
data1  in  8  requester 1 byte
ack1  out  1  one-cycle pulse for requester 1
ready  out  1  high once the init sequence has completed; stays high until reset
busy  out  1  high whenever state != IDLE
lcd_e  out  1  LCD enable
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; constant 0, write-only
lcd_data  out  8  LCD data bus

Behaviour:
- Reset (rst=0, async): state=PWR; every output 0 (lcd_e, lcd_rs, lcd_rw, lcd_data, ack0, ack1, ready, busy); RR pointer set so port 0 wins the first tie.
- Reset mid-transfer aborts immediately: lcd_e drops asynchronously. After release the full init sequence reruns.
- States: PWR, IDLE, SETUP, EN, HOLD, WAIT. Each timed state lasts exactly its parameter in cycles, using one down-counter sized for the max parameter.
- PWR: count PWR_WAIT cycles, then issue init commands in order, each as a full transfer with rs=0: 8'h3C, 8'h0C, 8'h06, 8'h01. No acks during init; requests are held off.
- After the last init WAIT: ready=1, go to IDLE.
- IDLE with ready and any req:
  - On that edge, pick the winner, pulse its ack for one cycle, latch its rs and data onto lcd_rs/lcd_data, go to SETUP.
  - Inputs are not sampled again until the next IDLE.
- Transfer sequence:
  - SETUP: lcd_e=0.
  - EN: lcd_e=1.
  - HOLD: lcd_e=0, bus unchanged.
  - WAIT: lcd_e=0, then return to IDLE.
- Wait length: CLR_WAIT if rs=0 and data[7:2]==0 (clear or return-home); otherwise CMD_WAIT.
- Transfer length: one accept cycle in IDLE plus SETUP_CYC+E_CYC+HOLD_CYC+WAIT cycles. Back-to-back requests are accepted in the first IDLE cycle.
- lcd_rs/lcd_data hold their last value in IDLE. lcd_rw is never 1.
- Arbitration:
  - Single request: that port wins.
  - Both requesting: the port not granted last wins; the pointer updates on each grant.
  - A request dropped before ack is legal and is simply not served.
- ack0 and ack1 are never high in the same cycle. A request is never acked twice.

Optional Feature:
LCD_FIXED_PRIO_EN
- Defined: strict priority, req0 always beats req1; RR pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Package lcd_pkg:
  - state enum
  - init command constants: LCD_FUNC_SET=8'h3C, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_HOME=8'h02
  - DDRAM line base addresses 8'h80 and 8'hC0
- Sub-module lcd_xfer_timer: SETUP/EN/HOLD/WAIT engine.
  - Inputs: start, rs, data, long_wait.
  - Outputs: done, lcd_e and the bus.
  - Used by both the init sequencer and the arbiter path.

Test Plan:
- Power-up, no requests:
  - lcd_data shows 3C, 0C, 06, 01 with rs=0, each with exactly E_CYC high cycles of lcd_e.
  - First lcd_e rises PWR_WAIT+1+SETUP_CYC cycles after rst deasserts.
  - ready rises after the 01 transfer's CLR_WAIT.
- Request held during init: req0=1, rs0=1, data0=8'h48 from time 0.
  - No ack0 before ready.
  - ack0 pulses on the first IDLE edge.
  - lcd_e pulse carries rs=1, data=48.
- Simultaneous requests: req0/req1 held continuously with 8'h41/8'h42.
  - Grants alternate 0,1,0,1.
  - Bus shows 41,42,41,42 at CMD_WAIT spacing.
  - ack0 and ack1 are never coincident.
- Clear command: req1 with rs1=0, data1=8'h01.
  - The next accept occurs no earlier than CLR_WAIT wait cycles after lcd_e falls.
  - 8'h80 uses CMD_WAIT.
- Reset mid-transfer: assert rst during EN.
  - lcd_e=0 and all outputs 0 immediately.
  - After release the init sequence restarts from 3C.
- LCD_FIXED_PRIO_EN build, both requests held:
  - Only port 0 is served while req0 stays high.
  - Port 1 is served once req0 drops.
